// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Decode/branch strobes into, and PC/stack status out of, pc_sequencer.
// Revision : 1.0
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_W        = 16,
    parameter int BR_IMM_W    = 6,
    parameter int J_IMM_W     = 12,
    parameter int STACK_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(STACK_DEPTH + 1);

    logic                clk_en;
    logic                branch_taken;
    logic [BR_IMM_W-1:0] branch_imm;
    logic                jump_taken;
    logic                call_taken;
    logic                ret_taken;
    logic                halt_cmd;
    logic [J_IMM_W-1:0]  jump_imm;
    logic [PC_W-1:0]     pc;
    logic                halted;
    logic [c_CNT_W-1:0]  stack_count;
    logic                stack_ovf;
    logic                stack_unf;
    logic                int_req;
    logic                int_en_cmd;
    logic                int_dis_cmd;
    logic                int_ack;

    modport master (
        output clk_en, branch_taken, branch_imm, jump_taken, call_taken,
               ret_taken, halt_cmd, jump_imm, int_req, int_en_cmd, int_dis_cmd,
        input  pc, halted, stack_count, stack_ovf, stack_unf, int_ack
    );

    modport slave (
        input  clk_en, branch_taken, branch_imm, jump_taken, call_taken,
               ret_taken, halt_cmd, jump_imm, int_req, int_en_cmd, int_dis_cmd,
        output pc, halted, stack_count, stack_ovf, stack_unf, int_ack
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with branch/jump/call/return, halt state and a
//            circular return-address stack. Interrupt support is built only
//            when PC_SEQ_INT_EN is defined.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter int              BR_IMM_W    = 6,
    parameter int              J_IMM_W     = 12,
    parameter int              STACK_DEPTH = 4,
    parameter int              INSTR_BYTES = 2,
    parameter logic [PC_W-1:0] INT_VECTOR  = 'h0040
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pc_sequencer_if.slave     bus
);

    localparam int                 c_CNT_W   = $clog2(STACK_DEPTH + 1);
    localparam int                 c_SP_W    = $clog2(STACK_DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(STACK_DEPTH);
    localparam logic [c_SP_W-1:0]  c_SP_LAST = c_SP_W'(STACK_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [PC_W-1:0]     r_pc, w_pc_next;
    logic [PC_W-1:0]     w_seq, w_br_tgt, w_j_tgt, w_run_next, w_push_data, w_top;
    logic [PC_W-1:0]     r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0]   r_sp, w_sp_inc, w_sp_dec;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf, r_unf, r_int_en, r_int_ack;
    logic                w_push, w_pop, w_ovf_set, w_unf_set;
    logic                w_int_en_next, w_int_ack_next, w_int_fire;
    logic                w_full, w_empty;

    assign w_seq    = r_pc + PC_W'(INSTR_BYTES);
    assign w_br_tgt = w_seq + {{(PC_W-BR_IMM_W){bus.branch_imm[BR_IMM_W-1]}}, bus.branch_imm};
    assign w_j_tgt  = w_seq + {{(PC_W-J_IMM_W){bus.jump_imm[J_IMM_W-1]}}, bus.jump_imm};

    // r_sp points at the next free slot; when full it also points at the oldest entry
    assign w_sp_inc = (r_sp == c_SP_LAST) ? '0 : r_sp + c_SP_W'(1);
    assign w_sp_dec = (r_sp == '0) ? c_SP_LAST : r_sp - c_SP_W'(1);
    assign w_top    = r_stack[w_sp_dec];
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);

`ifdef PC_SEQ_INT_EN
    assign w_int_fire = bus.int_req & r_int_en;
`else
    assign w_int_fire = 1'b0;
    logic w_unused_int;
    assign w_unused_int = bus.int_req | bus.int_en_cmd | bus.int_dis_cmd;
`endif

    // Target PC while running, also the interrupt return address
    always_comb begin
        w_run_next = w_seq;
        if (bus.halt_cmd)
            w_run_next = w_seq;
        else if (bus.ret_taken)
            w_run_next = w_empty ? w_seq : w_top;
        else if (bus.call_taken || bus.jump_taken)
            w_run_next = w_j_tgt;
        else if (bus.branch_taken)
            w_run_next = w_br_tgt;
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_push_data    = w_seq;
        w_unf_set      = 1'b0;
        w_int_en_next  = r_int_en;
        w_int_ack_next = 1'b0;
        if (bus.clk_en) begin
`ifdef PC_SEQ_INT_EN
            if (bus.int_dis_cmd)
                w_int_en_next = 1'b0;
            else if (bus.int_en_cmd)
                w_int_en_next = 1'b1;
`endif
            if (w_int_fire) begin
                w_push         = 1'b1;
                w_push_data    = (r_state == ST_HALTED) ? r_pc : w_run_next;
                w_pc_next      = INT_VECTOR;
                w_int_en_next  = 1'b0;
                w_state_next   = ST_RUN;
                w_int_ack_next = 1'b1;
            end else if (r_state == ST_RUN) begin
                w_pc_next = w_run_next;
                if (bus.halt_cmd)
                    w_state_next = ST_HALTED;
                else if (bus.ret_taken) begin
                    if (w_empty)
                        w_unf_set = 1'b1;
                    else
                        w_pop = 1'b1;
                end else if (bus.call_taken)
                    w_push = 1'b1;
            end
        end
    end

    assign w_ovf_set = w_push & w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_pc      <= '0;
            r_sp      <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_int_en  <= 1'b0;
            r_int_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_int_en  <= w_int_en_next;
            r_int_ack <= w_int_ack_next;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            if (w_unf_set)
                r_unf <= 1'b1;
            if (w_push) begin
                r_sp <= w_sp_inc;
                if (!w_full)
                    r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop) begin
                r_sp    <= w_sp_dec;
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_stack[r_sp] <= w_push_data;
    end

    assign bus.pc          = r_pc;
    assign bus.halted      = (r_state == ST_HALTED);
    assign bus.stack_count = r_count;
    assign bus.stack_ovf   = r_ovf;
    assign bus.stack_unf   = r_unf;
    assign bus.int_ack     = r_int_ack;

endmodule
`default_nettype wire
